// File: rtl/switch_input_conditioner_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : switch_input_conditioner_pkg                             |
// | Description : Shared constants and helpers for the switch/key input    |
// |               conditioning path (edge modes, default debounce time).   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package switch_input_conditioner_pkg;

  // Edge selection for the capture register
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  // 20 ms of stability at 50 MHz
  localparam int DEBOUNCE_CYCLES_50MHZ = 1000000;

  // True when an accepted transition to 'level' should set the capture flag
  function automatic logic edge_qualifies(input int mode, input logic level);
    case (mode)
      EDGE_RISING:  return level;
      EDGE_FALLING: return !level;
      default:      return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_input_conditioner_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : switch_input_conditioner_if                              |
// | Description : Pin-side / PIO-side signal bundle of the switch input    |
// |               conditioner. master = stimulus/bus side, slave = block.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface switch_input_conditioner_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] capture_clear;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] edge_capture;
  logic             irq;

  modport master (
    output sw_raw, capture_clear, irq_mask,
    input  sw_stable, edge_capture, irq
  );

  modport slave (
    input  sw_raw, capture_clear, irq_mask,
    output sw_stable, edge_capture, irq
  );
endinterface
`default_nettype wire

// File: rtl/switch_input_conditioner_debounce_bit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : switch_input_conditioner_debounce_bit                    |
// | Description : One input bit: 2-flop synchroniser, stability counter,   |
// |               debounced level and sticky write-1-to-clear edge flag.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module switch_input_conditioner_debounce_bit
  import switch_input_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   EDGE_MODE       = EDGE_BOTH,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw_raw,
  input  logic i_capture_clear,
  output logic o_sw_stable,
  output logic o_edge_capture
);

  localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic               r_capture;
  logic [c_cnt_w-1:0] r_cnt;

  logic w_differ;
  logic w_accept;
  logic w_event;

  // A change is accepted once it has differed for DEBOUNCE_CYCLES consecutive edges
  assign w_differ = (r_sync2 != r_stable);
  assign w_accept = w_differ && (r_cnt == c_cnt_max);
  assign w_event  = w_accept && edge_qualifies(EDGE_MODE, r_sync2);

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter; any return to the stable level restarts it from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= RESET_VAL;
    end else if (!w_differ) begin
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else begin
      r_cnt    <= r_cnt + c_cnt_w'(1);
    end
  end

  // Sticky capture flag; a new event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capture <= 1'b0;
    end else if (w_event) begin
      r_capture <= 1'b1;
    end else if (i_capture_clear) begin
      r_capture <= 1'b0;
    end
  end

  assign o_sw_stable    = r_stable;
  assign o_edge_capture = r_capture;

endmodule
`default_nettype wire

// File: rtl/switch_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : switch_input_conditioner                                 |
// | Description : Conditions raw SW[]/KEY[] pins for the PIO input export: |
// |               per-bit sync + debounce + edge capture, maskable IRQ.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module switch_input_conditioner
  import switch_input_conditioner_pkg::*;
#(
  parameter int               WIDTH           = 16,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int               EDGE_MODE       = EDGE_BOTH,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_reset_n,
  switch_input_conditioner_if.slave   bus
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_capture;

  // Bits are fully independent: one conditioner per input
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_input_conditioner_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .EDGE_MODE       (EDGE_MODE),
        .RESET_VAL       (RESET_VAL[i])
      ) u_bit (
        .clk             (CLOCK_50),
        .rst_n           (reset_reset_n),
        .i_sw_raw        (bus.sw_raw[i]),
        .i_capture_clear (bus.capture_clear[i]),
        .o_sw_stable     (w_stable[i]),
        .o_edge_capture  (w_capture[i])
      );
    end
  endgenerate

  // Level interrupt straight from the capture flops; mask acts immediately
  assign bus.irq          = |(w_capture & bus.irq_mask);
  assign bus.sw_stable    = w_stable;
  assign bus.edge_capture = w_capture;

endmodule
`default_nettype wire

// File: tb/tb_switch_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_switch_input_conditioner                              |
// | Description : Scoreboard bench: a sliding-window reference model       |
// |               predicts each cycle's outputs; a monitor compares them.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_switch_input_conditioner;

  localparam int         W  = 4;
  localparam int         DC = 4;
  localparam logic [W-1:0] RV = '0;

  typedef struct packed {
    logic [W-1:0] stable;
    logic [W-1:0] cap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  switch_input_conditioner_if #(.WIDTH(W)) bus ();

  switch_input_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .EDGE_MODE       (2),
    .RESET_VAL       (RV)
  ) dut (
    .CLOCK_50      (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted when the synchronised input has been
  // the opposite of the current stable level for the last DC edges in a row.
  logic [W-1:0] m_s1, m_s2, m_stable, m_cap;
  logic [W-1:0] m_win[$];
  exp_t         exp_q[$];

  always @(posedge clk) begin : model
    logic [W-1:0] acc;
    bit           all_diff;
    if (!rst_n) begin
      m_s1 = RV; m_s2 = RV; m_stable = RV; m_cap = '0;
      m_win.delete();
    end else begin
      m_win.push_back(m_s2);
      if (m_win.size() > DC) void'(m_win.pop_front());
      acc = '0;
      for (int i = 0; i < W; i++) begin
        if (m_win.size() == DC) begin
          all_diff = 1'b1;
          for (int k = 0; k < DC; k++)
            if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
          acc[i] = all_diff;
        end
      end
      m_cap    = acc | (m_cap & ~bus.capture_clear);
      m_stable = m_stable ^ acc;
      m_s2     = m_s1;
      m_s1     = bus.sw_raw;
    end
    exp_q.push_back('{stable: m_stable, cap: m_cap});
  end

  // Monitor: compare the DUT against the oldest prediction each cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sw_stable",    bus.sw_stable,    e.stable);
      check("edge_capture", bus.edge_capture, e.cap);
      check("irq", W'(bus.irq), W'(|(e.cap & bus.irq_mask)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts edges until sw_stable[b] reaches v, bounded
  task automatic measure(input string name, input int b, input logic v, input int exp_n);
    int n;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.sw_stable[b] === v) begin
        n = k;
        break;
      end
    end
    #1;
    check(name, W'(n), W'(exp_n));
  endtask

  task automatic pulse_clear(input logic [W-1:0] v);
    bus.capture_clear = v;
    cyc(1);
    bus.capture_clear = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.sw_raw        = 4'hF;
    bus.capture_clear = '0;
    bus.irq_mask      = '0;

    // Reset with all pins high, then full debounce after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    measure("reset_accept_latency", 0, 1'b1, 6);
    cyc(2);
    check("reset_accept_all", bus.sw_stable, 4'hF);

    // Return to all-low and clear flags
    bus.sw_raw = 4'h0;
    cyc(10);
    pulse_clear(4'hF);
    cyc(2);
    check("cleared", bus.edge_capture, 4'h0);

    // Clean step on bit 0
    bus.sw_raw[0] = 1'b1;
    measure("step_latency", 0, 1'b1, 6);
    check("step_capture", bus.edge_capture, 4'h1);
    cyc(2);

    // Bounce on bit 1: runs of 3 and 2 never accepted
    bus.sw_raw[1] = 1'b1; cyc(3);
    bus.sw_raw[1] = 1'b0; cyc(1);
    bus.sw_raw[1] = 1'b1; cyc(2);
    bus.sw_raw[1] = 1'b0; cyc(8);
    check("bounce_stable", bus.sw_stable & 4'h2, 4'h0);
    check("bounce_capture", bus.edge_capture & 4'h2, 4'h0);

    // Clear coincident with the accept edge of bit 2: set wins
    pulse_clear(4'hF);
    bus.sw_raw[2] = 1'b1;
    cyc(5);
    pulse_clear(4'h4);
    cyc(1);
    check("race_set_wins", bus.edge_capture & 4'h4, 4'h4);
    pulse_clear(4'h4);
    cyc(1);
    check("later_clear", bus.edge_capture & 4'h4, 4'h0);

    // IRQ masking with capture = 4'h3
    bus.sw_raw[0] = 1'b0;
    bus.sw_raw[1] = 1'b1;
    cyc(8);
    check("mask_setup", bus.edge_capture, 4'h3);
    bus.irq_mask = 4'h4; #1;
    check("irq_masked", W'(bus.irq), W'(0));
    bus.irq_mask = 4'h1; #1;
    check("irq_unmasked", W'(bus.irq), W'(1));
    cyc(1);
    pulse_clear(4'h1);
    check("irq_after_clear", W'(bus.irq), W'(0));
    cyc(2);

    // Reset in the middle of a bit-3 count
    pulse_clear(4'hF);
    bus.sw_raw[3] = 1'b1;
    cyc(4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("midcount_reset", bus.sw_stable, 4'h0);
    measure("redebounce_latency", 3, 1'b1, 6);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      bus.capture_clear = '0;
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) bus.sw_raw[i] = ~bus.sw_raw[i];
      if ($urandom_range(0, 7) == 0) bus.capture_clear = W'($urandom);
      if ($urandom_range(0, 15) == 0) bus.irq_mask = W'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end

    cyc(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
